// File: rtl/pipe_skid_slice.sv
// rtl/pipe_skid_slice.sv - two-entry valid/ready skid slice between pipeline stages
// Optional build macro PIPE_SKID_SLICE_PERF_EN adds stall_cnt/full_cnt performance counters.
module pipe_skid_slice #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_SLICE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      full_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    // Handshake outputs depend on registered state only, never on out_ready.
    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = (r_state != ST_FULL);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = in_data;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt  = in_data;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_skid_nxt  = in_data;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush drops everything held plus any same-cycle accept; data contents become don't-care.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
        end
    end

`ifdef PIPE_SKID_SLICE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_full_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_full_cnt  <= 32'd0;
        end else begin
            if (out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (r_state == ST_FULL) begin
                r_full_cnt <= r_full_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign full_cnt  = r_full_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_slice.sv
// tb/tb_pipe_skid_slice.sv - self-checking bench for pipe_skid_slice (vector table, hand sequences, random vs queue model)
module tb_pipe_skid_slice;

    localparam logic [31:0] RST_V = 32'hDEAD;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_SLICE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] full_cnt;
`endif

    pipe_skid_slice #(
        .WIDTH     (32),
        .RESET_VAL (RST_V)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_SLICE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .full_cnt  (full_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [31:0] ed;
        logic        cd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                       input logic ev, input logic er, input logic [31:0] ed, input logic cd);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.er = er; v.ed = ed; v.cd = cd;
        vq.push_back(v);
    endtask

    // Reference model: a bounded FIFO of depth 2 plus counter semantics.
    logic [31:0] mq[$];
    logic [31:0] m_stall;
    logic [31:0] m_full;

    task automatic model_edge(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] d, input logic ordy);
        bit ofire;
        bit ifire;
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_full  = 0;
        end else begin
            if (mq.size() > 0 && !ordy) m_stall = m_stall + 1;
            if (mq.size() == 2) m_full = m_full + 1;
            if (fl) begin
                mq.delete();
            end else begin
                ofire = (mq.size() > 0) && ordy;
                ifire = iv && (mq.size() < 2);
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(d);
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_data",  out_data, RST_V);
        reset = 1'b0;

        // Stream, backpressure fill/drain, simultaneous in/out in ONE, flush while FULL, flush with out fire.
        add(0,1,32'h11,1, 1,1,32'h11,1);
        add(0,1,32'h22,1, 1,1,32'h22,1);
        add(0,1,32'h33,1, 1,1,32'h33,1);
        add(0,0,32'h0 ,1, 0,1,32'h0 ,0);
        add(0,1,32'hA ,0, 1,1,32'hA ,1);
        add(0,1,32'hB ,0, 1,0,32'hA ,1);
        add(0,1,32'hF ,0, 1,0,32'hA ,1);
        add(0,0,32'h0 ,0, 1,0,32'hA ,1);
        add(0,0,32'h0 ,0, 1,0,32'hA ,1);
        add(0,0,32'h0 ,0, 1,0,32'hA ,1);
        add(0,0,32'h0 ,1, 1,1,32'hB ,1);
        add(0,0,32'h0 ,1, 0,1,32'h0 ,0);
        add(0,1,32'h5 ,0, 1,1,32'h5 ,1);
        add(0,1,32'h6 ,1, 1,1,32'h6 ,1);
        add(0,0,32'h0 ,0, 1,1,32'h6 ,1);
        add(0,0,32'h0 ,1, 0,1,32'h0 ,0);
        add(0,1,32'hC ,0, 1,1,32'hC ,1);
        add(0,1,32'hD ,0, 1,0,32'hC ,1);
        add(1,1,32'hE ,0, 0,1,32'h0 ,0);
        add(0,0,32'h0 ,1, 0,1,32'h0 ,0);
        add(0,1,32'h7 ,0, 1,1,32'h7 ,1);
        add(1,1,32'h8 ,1, 0,1,32'h0 ,0);
        add(0,0,32'h0 ,1, 0,1,32'h0 ,0);

        for (int i = 0; i < vq.size(); i++) begin
            flush = vq[i].fl; in_valid = vq[i].iv; in_data = vq[i].d; out_ready = vq[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vq[i].ev});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vq[i].er});
            if (vq[i].cd) chk($sformatf("vec%0d_out_data", i), out_data, vq[i].ed);
        end
        flush = 1'b0;

        // Reset while FULL, then confirm nothing stale is emitted.
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'h1C; tick();
        in_data = 32'h1D; tick();
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1; in_data = 32'h1E; tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_data",  out_data, RST_V);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst_idle%0d_valid", i), {31'd0, out_valid}, 32'd0);
        end

`ifdef PIPE_SKID_SLICE_PERF_EN
        reset = 1'b1; tick(); reset = 1'b0;
        chk("perf_reset_stall", stall_cnt, 32'd0);
        chk("perf_reset_full",  full_cnt,  32'd0);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("perf_stall_cnt", stall_cnt, 32'd7);
        chk("perf_full_cnt",  full_cnt,  32'd6);
`endif

        // Randomized traffic against the queue model.
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        model_edge(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            tick();
            model_edge(reset, flush, in_valid, in_data, out_ready);
            chk($sformatf("rnd%0d_out_valid", c), {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk($sformatf("rnd%0d_in_ready", c),  {31'd0, in_ready},  {31'd0, mq.size() < 2});
            if (mq.size() > 0) chk($sformatf("rnd%0d_out_data", c), out_data, mq[0]);
            else if (reset) chk($sformatf("rnd%0d_rst_data", c), out_data, RST_V);
`ifdef PIPE_SKID_SLICE_PERF_EN
            chk($sformatf("rnd%0d_stall_cnt", c), stall_cnt, m_stall);
            chk($sformatf("rnd%0d_full_cnt", c),  full_cnt,  m_full);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
